// File: rtl/mul_wb.sv
// mul_wb: sequential 16x16 unsigned shift-add multiplier with register-file
// write-back. One multiply takes 16 BUSY cycles, then one write-back cycle
// for the low half of the product.
// Optional feature macro: MUL_HI_WRITE_EN -- when defined, a second
// write-back cycle (WB_HI) stores the high half to register (dst_addr+1) mod 32.
module mul_wb (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] Rsrc1,
   input  logic [15:0] Rsrc2,
   input  logic [4:0]  dst_addr,
   output logic        busy,
   output logic [15:0] Rdst,
   output logic [4:0]  Rdst_addr,
   output logic        Rwrite,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
`ifdef MUL_HI_WRITE_EN
      WB_LO = 2'd2,
      WB_HI = 2'd3
`else
      WB_LO = 2'd2
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
   logic [15:0] mplier_q, mplier_d; // multiplier, shifted right each step
   logic [31:0] prod_q, prod_d;     // full-width accumulator, never overflows
   logic [4:0]  cnt_q, cnt_d;       // BUSY steps taken so far
   logic [4:0]  addr_q, addr_d;     // destination index captured with start

   // State and datapath registers, synchronous active-high reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
      end
   end

   // Next-state and shift-add datapath.
   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = {16'd0, Rsrc1};
               mplier_d = Rsrc2;
               addr_d   = dst_addr;
               prod_d   = '0;
               cnt_d    = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (mplier_q[0]) begin
               prod_d = prod_q + mcand_q;
            end
            mcand_d  = {mcand_q[30:0], 1'b0};
            mplier_d = {1'b0, mplier_q[15:1]};
            cnt_d    = cnt_q + 5'd1;
            // The 16th step happens on the edge where the count reads 15.
            if (cnt_q == 5'd15) begin
               state_d = WB_LO;
            end
         end
         WB_LO: begin
`ifdef MUL_HI_WRITE_EN
            state_d = WB_HI;
`else
            state_d = IDLE;
`endif
         end
`ifdef MUL_HI_WRITE_EN
         WB_HI: begin
            state_d = IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded purely from registered state; inputs never reach them.
   always_comb begin
      busy      = (state_q != IDLE);
      Rwrite    = 1'b0;
      Rdst      = 16'd0;
      Rdst_addr = 5'd0;
      done      = 1'b0;
      unique case (state_q)
         WB_LO: begin
            Rwrite    = 1'b1;
            Rdst      = prod_q[15:0];
            Rdst_addr = addr_q;
`ifndef MUL_HI_WRITE_EN
            done      = 1'b1;
`endif
         end
`ifdef MUL_HI_WRITE_EN
         WB_HI: begin
            Rwrite    = 1'b1;
            Rdst      = prod_q[31:16];
            Rdst_addr = addr_q + 5'd1;  // 5-bit add wraps 31 to 0
            done      = 1'b1;
         end
`endif
         default: begin
            Rwrite = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mul_wb.sv
// tb_mul_wb: directed bench for mul_wb. Honours MUL_HI_WRITE_EN the same way
// the design does, expecting one or two write-back cycles accordingly.
module tb_mul_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] Rsrc1;
   logic [15:0] Rsrc2;
   logic [4:0]  dst_addr;
   logic        busy;
   logic [15:0] Rdst;
   logic [4:0]  Rdst_addr;
   logic        Rwrite;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;

   mul_wb dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .Rsrc1     (Rsrc1),
      .Rsrc2     (Rsrc2),
      .dst_addr  (dst_addr),
      .busy      (busy),
      .Rdst      (Rdst),
      .Rdst_addr (Rdst_addr),
      .Rwrite    (Rwrite),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Count every write the register file would sample.
   always @(posedge clk) begin
      if (Rwrite === 1'b1) wr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".busy"},   32'(busy),      32'd0);
      check({tag, ".rwrite"}, 32'(Rwrite),    32'd0);
      check({tag, ".done"},   32'(done),      32'd0);
      check({tag, ".rdst"},   32'(Rdst),      32'd0);
      check({tag, ".addr"},   32'(Rdst_addr), 32'd0);
   endtask

   // One full operation; start is sampled at edge 0. With disturb set, the
   // operands change after edge 3 and start is re-raised at edges 5, 16 and
   // the final write-back edge; none of that may alter the result.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] ad, input logic [31:0] exp_prod,
                         input bit disturb);
      int w0;
      int early;
      w0       = wr_cnt;
      early    = 0;
      Rsrc1    = a;
      Rsrc2    = b;
      dst_addr = ad;
      start    = 1'b1;
      tick();                                   // edge 0
      check({tag, ".busy_e0"}, 32'(busy), 32'd1);
      for (int e = 1; e <= 15; e++) begin
         start = disturb && (e == 5);
         if (disturb && e == 4) begin
            Rsrc1    = ~a;
            Rsrc2    = b ^ 16'h5A5A;
            dst_addr = ad ^ 5'h1F;
         end
         tick();
         if (Rwrite !== 1'b0 || busy !== 1'b1) early++;
      end
      check({tag, ".no_early_write"}, 32'(early), 32'd0);
      start = disturb;
      tick();                                   // edge 16
      start = 1'b0;
      check({tag, ".lo.rwrite"}, 32'(Rwrite),    32'd1);
      check({tag, ".lo.rdst"},   32'(Rdst),      32'(exp_prod[15:0]));
      check({tag, ".lo.addr"},   32'(Rdst_addr), 32'(ad));
      check({tag, ".lo.busy"},   32'(busy),      32'd1);
`ifdef MUL_HI_WRITE_EN
      check({tag, ".lo.done"},   32'(done),      32'd0);
      tick();                                   // edge 17
      check({tag, ".hi.rwrite"}, 32'(Rwrite),    32'd1);
      check({tag, ".hi.rdst"},   32'(Rdst),      32'(exp_prod[31:16]));
      check({tag, ".hi.addr"},   32'(Rdst_addr), 32'(5'(ad + 5'd1)));
      check({tag, ".hi.done"},   32'(done),      32'd1);
`else
      check({tag, ".lo.done"},   32'(done),      32'd1);
`endif
      start = disturb;
      tick();                                   // back to IDLE
      start = 1'b0;
      check_quiet({tag, ".after"});
      tick();                                   // a start in the last WB cycle is not queued
      check({tag, ".not_queued"}, 32'(busy), 32'd0);
`ifdef MUL_HI_WRITE_EN
      check({tag, ".writes"}, 32'(wr_cnt - w0), 32'd2);
`else
      check({tag, ".writes"}, 32'(wr_cnt - w0), 32'd1);
`endif
   endtask

   initial begin
      int w0;
      rst      = 1'b1;
      start    = 1'b1;           // reset must win over start
      Rsrc1    = 16'h1111;
      Rsrc2    = 16'h2222;
      dst_addr = 5'd9;
      tick();
      tick();
      check_quiet("reset");
      rst   = 1'b0;
      start = 1'b0;
      tick();
      check("idle_no_start.busy", 32'(busy), 32'd0);

      // 47 * 74 = 3478 = 0x0D96
      run_op("basic", 16'd47, 16'd74, 5'd3, 32'd3478, 1'b0);
      // 0xFFFF * 0xFFFF = 0xFFFE0001
      run_op("max", 16'hFFFF, 16'hFFFF, 5'd5, 32'hFFFE_0001, 1'b0);
      // 0x0100 * 0x0100 = 0x00010000, high-half write wraps to R0
      run_op("wrap", 16'h0100, 16'h0100, 5'd31, 32'h0001_0000, 1'b0);
      // 0x8000 * 3 = 0x00018000, carries into the high half
      run_op("carry", 16'h8000, 16'h0003, 5'd12, 32'h0001_8000, 1'b0);

      // Reset at edge 8 aborts with no write-back.
      w0       = wr_cnt;
      Rsrc1    = 16'd9;
      Rsrc2    = 16'd9;
      dst_addr = 5'd2;
      start    = 1'b1;
      tick();                    // edge 0
      start = 1'b0;
      for (int e = 1; e <= 7; e++) tick();
      check("abort.busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();                    // edge 8
      rst = 1'b0;
      check_quiet("abort");
      check("abort.writes", 32'(wr_cnt - w0), 32'd0);

      // IDLE accepts a start right away; 0x1234 * 0x56 = 0x00061D78 with
      // operands disturbed and extra starts injected.
      run_op("disturb", 16'h1234, 16'h0056, 5'd20, 32'h0006_1D78, 1'b1);
      // Zero operand still takes 16 BUSY cycles and writes 0.
      run_op("zero", 16'h0000, 16'h1234, 5'd7, 32'h0000_0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mul_wb.md
MUL_WB -- requirements
Module: mul_wb

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- Rsrc1  input  16  multiplicand, taken from register-file read port 1.
- Rsrc2  input  16  multiplier, taken from register-file read port 2.
- dst_addr  input  5  destination register index; captured with start.
- busy  output  1  high whenever state is not IDLE.
- Rdst  output  16  write-back data to the register file.
- Rdst_addr  output  5  write-back register index.
- Rwrite  output  1  register-file write enable.
- done  output  1  one-cycle pulse during the final write-back cycle.
REQ-002 SHALL use one clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-003 SHALL implement the states IDLE, BUSY, WB_LO and, when configured, WB_HI.
REQ-004 In IDLE with start=1 at an edge, SHALL capture Rsrc1, Rsrc2 and dst_addr, clear the 32-bit product and the 5-bit counter, and enter BUSY.
REQ-005 In IDLE with start=0, SHALL remain in IDLE.
REQ-006 In BUSY, each edge SHALL perform one unsigned shift-add step (if the multiplier LSB is 1, add the multiplicand to the product; shift the multiplier right and the multiplicand left).
REQ-007 The counter SHALL increment on every BUSY edge.
REQ-008 After 16 BUSY edges, SHALL enter WB_LO.
REQ-009 The product SHALL be the full 32-bit unsigned result, with no overflow loss.
REQ-010 In WB_LO: Rwrite=1, Rdst=product[15:0], Rdst_addr=captured dst_addr.
REQ-011 Outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.
REQ-012 With start sampled at edge 0, Rwrite SHALL be high in the cycle following edge 16, so the register file samples the write at edge 17.
REQ-013 Rwrite SHALL be high for exactly one cycle per write-back state.
REQ-014 Outside write-back states, Rwrite=0, Rdst=16'd0 and Rdst_addr=5'd0.
REQ-015 done SHALL pulse concurrently with the last write-back state, and the block SHALL return to IDLE on the next edge.
REQ-016 start while busy=1, including during the last write-back cycle, SHALL be ignored and not queued.
REQ-017 Rsrc1, Rsrc2 and dst_addr changes after capture SHALL NOT affect the in-flight operation.
REQ-018 An operand of zero SHALL still take the full 16 BUSY cycles and write 0.

Reset
REQ-019 rst=1 at an edge SHALL force IDLE, clear the product, counter and captured operands, and drive busy=0, Rwrite=0, done=0, Rdst=0 and Rdst_addr=0 from the following cycle.
REQ-020 rst SHALL take priority over start.
REQ-021 Reset mid-operation SHALL abort the operation with no write-back.

Configuration
REQ-022 The macro MUL_HI_WRITE_EN SHALL control whether the high half of the product is written back.
REQ-023 With MUL_HI_WRITE_EN defined, WB_LO SHALL be followed by WB_HI, in which Rwrite=1, Rdst=product[31:16] and Rdst_addr=(dst_addr+1) mod 32.
REQ-024 With MUL_HI_WRITE_EN defined, done SHALL pulse in WB_HI (edge 18 write).
REQ-025 With MUL_HI_WRITE_EN defined, dst_addr=31 SHALL wrap the high-half write to register 0.
REQ-026 Without MUL_HI_WRITE_EN, WB_HI SHALL not exist, done SHALL pulse in WB_LO, and product[31:16] SHALL be discarded.

Verification
REQ-027 A bench SHALL cover the following directed scenarios:
- Rsrc1=47, Rsrc2=74, dst_addr=3, start at edge 0 -> Rwrite=1 in cycle after edge 16, Rdst=3478, Rdst_addr=3, done=1, busy=0 after edge 17.
- MUL_HI_WRITE_EN defined, Rsrc1=Rsrc2=16'hFFFF, dst_addr=5 -> write 16'h0001 to R5, then 16'hFFFE to R6 on the next cycle, done only with the second write.
- MUL_HI_WRITE_EN defined, dst_addr=31, Rsrc1=16'h0100, Rsrc2=16'h0100 -> R31=16'h0000, then R0=16'h0001.
- Start op, assert rst at edge 8 -> busy=0 from the next cycle, no Rwrite pulse ever, IDLE accepts a new start immediately.
- Second start pulsed at edges 5 and 16 of an active op -> only one write-back, with the first operands; Rsrc1/Rsrc2 changed at edge 3 do not alter the result.
- Rsrc1=0, Rsrc2=16'h1234 -> Rwrite after exactly 16 BUSY cycles, Rdst=0.
